// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment readback monitor.
// Segment patterns are active-low with bit0=a .. bit6=g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIR_FIRST = 2'b00,
    DIR_UP    = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_JUMP  = 2'b11
  } dir_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
    return 7'(tens) * 7'd10 + 7'(units);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to digit decoder.
// A blank pattern is accepted as digit 0 only when i_blank_ok is set.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  input  logic       i_blank_ok,
  output logic       o_valid,
  output logic [3:0] o_digit
);

  always_comb begin
    o_valid = 1'b1;
    o_digit = '0;
    case (i_seg)
      SEG_0:     o_digit = 4'd0;
      SEG_1:     o_digit = 4'd1;
      SEG_2:     o_digit = 4'd2;
      SEG_3:     o_digit = 4'd3;
      SEG_4:     o_digit = 4'd4;
      SEG_5:     o_digit = 4'd5;
      SEG_6:     o_digit = 4'd6;
      SEG_7:     o_digit = 4'd7;
      SEG_8:     o_digit = 4'd8;
      SEG_9:     o_digit = 4'd9;
      SEG_BLANK: o_valid = i_blank_ok;
      default:   o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Debounces a two-digit seven-segment display, decodes it back to 0..99
// and classifies each newly accepted value against the previous one.
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned WRAP_MAX      = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] HEX0,
  input  logic [6:0] HEX1,
  output logic [6:0] value,
  output logic       value_valid,
  output logic       update,
  output logic [1:0] dir,
  output logic       err,
  output logic       stable
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);
  localparam logic [7:0] WRAP8      = 8'(WRAP_MAX);

  logic [13:0] r_samp;
  logic [3:0]  r_cnt;
  logic        r_fired;
  state_t      r_state;
  logic [6:0]  r_value;
  logic        r_valid;
  logic        r_update;
  dir_t        r_dir;
  logic        r_err;

  logic [13:0] w_sample;
  logic        w_change;
  logic        w_accept;
  logic        w_tens_ok;
  logic        w_units_ok;
  logic [3:0]  w_tens;
  logic [3:0]  w_units;
  logic        w_dec_ok;
  logic [6:0]  w_dec;
  logic [7:0]  w_dec8;
  logic [7:0]  w_val8;
  logic        w_is_up;
  logic        w_is_down;

  state_t      w_state_nx;
  logic [6:0]  w_value_nx;
  logic        w_valid_nx;
  dir_t        w_dir_nx;
  logic        w_update_nx;
  logic        w_err_nx;

  assign w_sample = {HEX1, HEX0};
  assign w_change = (w_sample != r_samp);
  // r_fired keeps a saturated count from re-accepting the same held pattern.
  assign w_accept = (r_cnt == STABLE_CNT) && !r_fired;

  seg7_decode u_dec_tens (
    .i_seg      (r_samp[13:7]),
    .i_blank_ok (1'b1),
    .o_valid    (w_tens_ok),
    .o_digit    (w_tens)
  );

  seg7_decode u_dec_units (
    .i_seg      (r_samp[6:0]),
    .i_blank_ok (1'b0),
    .o_valid    (w_units_ok),
    .o_digit    (w_units)
  );

  assign w_dec_ok = w_tens_ok && w_units_ok;
  assign w_dec    = bcd_to_bin(w_tens, w_units);
  // Neighbour tests are 8 bits wide so value-1 at zero cannot alias.
  assign w_dec8    = {1'b0, w_dec};
  assign w_val8    = {1'b0, r_value};
  assign w_is_up   = (w_dec8 == w_val8 + 8'd1) || ((w_val8 == WRAP8) && (w_dec8 == 8'd0));
  assign w_is_down = (w_dec8 == w_val8 - 8'd1) || ((w_val8 == 8'd0) && (w_dec8 == WRAP8));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_samp  <= '0;
      r_cnt   <= '0;
      r_fired <= 1'b0;
    end else begin
      r_samp <= w_sample;
      if (w_change) begin
        r_cnt   <= '0;
        r_fired <= 1'b0;
      end else begin
        if (r_cnt != STABLE_CNT) r_cnt <= r_cnt + 4'd1;
        if (w_accept) r_fired <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_value_nx  = r_value;
    w_valid_nx  = r_valid;
    w_dir_nx    = r_dir;
    w_update_nx = 1'b0;
    w_err_nx    = 1'b0;
    if (w_accept) begin
      if (!w_dec_ok) begin
        w_err_nx = 1'b1;
      end else begin
        case (r_state)
          S_EMPTY: begin
            w_value_nx  = w_dec;
            w_valid_nx  = 1'b1;
            w_dir_nx    = DIR_FIRST;
            w_update_nx = 1'b1;
            w_state_nx  = S_HOLD;
          end
          S_HOLD: begin
            if (w_dec != r_value) begin
              w_value_nx  = w_dec;
              w_update_nx = 1'b1;
              if (w_is_up)        w_dir_nx = DIR_UP;
              else if (w_is_down) w_dir_nx = DIR_DOWN;
              else                w_dir_nx = DIR_JUMP;
            end
          end
          default: w_state_nx = S_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_EMPTY;
      r_value  <= '0;
      r_valid  <= 1'b0;
      r_dir    <= DIR_FIRST;
      r_update <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_value  <= w_value_nx;
      r_valid  <= w_valid_nx;
      r_dir    <= w_dir_nx;
      r_update <= w_update_nx;
      r_err    <= w_err_nx;
    end
  end

  assign value       = r_value;
  assign value_valid = r_valid;
  assign update      = r_update;
  assign dir         = r_dir;
  assign err         = r_err;
  assign stable      = (r_cnt == STABLE_CNT);

endmodule

// File: tb/tb_seg7_readback.sv
// Bench for seg7_readback: directed vector table, randomized patterns checked
// cycle by cycle against a run-length reference model, and reset corner cases.
module tb_seg7_readback;

  localparam int S  = 4;
  localparam int WM = 99;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] HEX0, HEX1;
  logic [6:0] value;
  logic       value_valid, update, err, stable;
  logic [1:0] dir;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_value, m_valid, m_dir, m_upd, m_err, m_run;
  logic [13:0] m_last;

  typedef struct {
    logic [6:0] h1;
    logic [6:0] h0;
    int hold;
    int ev;
    int edir;
    int evalid;
    int eupd;
    int eerr;
  } vec_t;

  vec_t tbl[15];

  seg7_readback #(.STABLE_CYCLES(S), .WRAP_MAX(WM)) dut (
    .clk         (clk),
    .reset       (reset),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .value       (value),
    .value_valid (value_valid),
    .update      (update),
    .dir         (dir),
    .err         (err),
    .stable      (stable)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return D0; 1: return D1; 2: return D2; 3: return D3; 4: return D4;
      5: return D5; 6: return D6; 7: return D7; 8: return D8; default: return D9;
    endcase
  endfunction

  function automatic int seg2dig(input logic [6:0] p, input bit blank_ok);
    for (int d = 0; d < 10; d++) if (p == seg_of(d)) return d;
    if (blank_ok && p == BL) return 0;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_value = 0; m_valid = 0; m_dir = 0; m_upd = 0; m_err = 0;
    m_last  = '0;
    m_run   = 1;
  endtask

  // A pattern is accepted on the edge after it has been sampled S+1 times in a row.
  task automatic model_edge();
    int t, u, v;
    logic [13:0] cur;
    if (!reset) return;
    m_upd = 0;
    m_err = 0;
    if (m_run == S + 1) begin
      t = seg2dig(m_last[13:7], 1'b1);
      u = seg2dig(m_last[6:0], 1'b0);
      if (t < 0 || u < 0) begin
        m_err = 1;
      end else begin
        v = t * 10 + u;
        if (m_valid == 0) begin
          m_value = v; m_valid = 1; m_dir = 0; m_upd = 1;
        end else if (v != m_value) begin
          if (v == (m_value + 1) % (WM + 1))       m_dir = 1;
          else if (v == (m_value + WM) % (WM + 1)) m_dir = 2;
          else                                     m_dir = 3;
          m_value = v;
          m_upd   = 1;
        end
      end
    end
    cur = {HEX1, HEX0};
    if (cur == m_last) begin
      if (m_run < S + 2) m_run++;
    end else begin
      m_last = cur;
      m_run  = 1;
    end
  endtask

  task automatic check_cycle(input string name);
    logic [12:0] act, exp;
    act = {value, value_valid, update, dir, err, stable};
    exp = {7'(m_value), m_valid[0], m_upd[0], 2'(m_dir), m_err[0], (m_run > S)};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual={val,vld,upd,dir,err,stb}=%h required=%h", name, $time, act, exp);
    end
    total++;
    if (update && err) begin
      bad++;
      $display("FAIL upd_err_excl t=%0t actual=both required=not_both", $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle("cycle");
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    model_reset();
    check_cycle("reset");
    repeat (cycles) tick();
    reset = 1'b1;
  endtask

  initial begin
    int nu, ne, lat, r, v;

    tbl[0]  = '{BL, D3, 10,  3, 0, 1, 1, 0};
    tbl[1]  = '{BL, D4, 10,  4, 1, 1, 1, 0};
    tbl[2]  = '{BL, D3, 10,  3, 2, 1, 1, 0};
    tbl[3]  = '{D9, D9, 10, 99, 3, 1, 1, 0};
    tbl[4]  = '{BL, D0, 10,  0, 1, 1, 1, 0};
    tbl[5]  = '{D9, D9, 10, 99, 2, 1, 1, 0};
    tbl[6]  = '{BL, D4, 10,  4, 3, 1, 1, 0};
    tbl[7]  = '{BL, D7,  3,  4, 3, 1, 0, 0};
    tbl[8]  = '{BL, D4, 10,  4, 3, 1, 0, 0};
    tbl[9]  = '{BL, D7, 10,  7, 3, 1, 1, 0};
    tbl[10] = '{BL, BL, 10,  7, 3, 1, 0, 1};
    tbl[11] = '{BL, 7'b0000001, 10, 7, 3, 1, 0, 1};
    tbl[12] = '{7'b0000001, D0, 10, 7, 3, 1, 0, 1};
    tbl[13] = '{D1, D0, 10, 10, 3, 1, 1, 0};
    tbl[14] = '{BL, D9, 10,  9, 2, 1, 1, 0};

    HEX1 = BL;
    HEX0 = D3;
    do_reset(2);

    for (int i = 0; i < 15; i++) begin
      HEX1 = tbl[i].h1;
      HEX0 = tbl[i].h0;
      nu = 0;
      ne = 0;
      for (int c = 0; c < tbl[i].hold; c++) begin
        tick();
        nu += int'(update);
        ne += int'(err);
      end
      chk($sformatf("vec%0d_value", i), int'(value), tbl[i].ev);
      chk($sformatf("vec%0d_dir", i), int'(dir), tbl[i].edir);
      chk($sformatf("vec%0d_valid", i), int'(value_valid), tbl[i].evalid);
      chk($sformatf("vec%0d_updates", i), nu, tbl[i].eupd);
      chk($sformatf("vec%0d_errs", i), ne, tbl[i].eerr);
    end

    // Randomized patterns, biased towards +/-1 neighbours of the current value
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 8) begin
        v = (r < 4) ? (m_value + 1) % (WM + 1) : (m_value + WM) % (WM + 1);
        HEX1 = (v / 10 == 0 && $urandom_range(0, 1) == 1) ? BL : seg_of(v / 10);
        HEX0 = seg_of(v % 10);
      end else if (r < 14) begin
        v = int'($urandom_range(0, 99));
        HEX1 = (v / 10 == 0) ? BL : seg_of(v / 10);
        HEX0 = seg_of(v % 10);
      end else if (r < 16) begin
        HEX0 = 7'($urandom);
      end else if (r < 18) begin
        HEX1 = 7'($urandom);
        HEX0 = 7'($urandom);
      end else if (r == 18) begin
        do_reset(int'($urandom_range(1, 2)));
      end
      repeat ($urandom_range(1, 8)) tick();
    end

    // Reset asserted while a new pattern is settling
    HEX1 = BL;
    HEX0 = D1;
    repeat (10) tick();
    HEX0 = D6;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_value", int'(value), 0);
    chk("rst_valid", int'(value_valid), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_stable", int'(stable), 0);
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (update && lat < 0) begin
        lat = k;
        break;
      end
    end
    chk("rst_latency", lat, S + 2);
    chk("rst_reacc_dir", int'(dir), 0);
    chk("rst_reacc_value", int'(value), 6);
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Reader for the two-digit seven-segment interface (HEX1 = tens digit, HEX0 = units digit) driven by the up/down counter.
- Samples the segment patterns and waits until they have been stable for a configurable number of cycles.
- Then decodes them back to a binary value 0..99 and classifies each new value against the previous one: step up, step down, wrap, or jump.
- Used as an on-chip/bench monitor beside the counter and as a source for later status logic.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (legal range 1..15).
- WRAP_MAX, 99, top count value; WRAP_MAX->0 counts as step up and 0->WRAP_MAX counts as step down.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset (asserted when 0)
- HEX0  in  7  units segments, active-low, bit0=a .. bit6=g
- HEX1  in  7  tens segments, same encoding
- value  out  7  last accepted decoded value, 0..99
- value_valid  out  1  level; high once any value has been accepted
- update  out  1  one-cycle pulse when value changes
- dir  out  2  classification latched with update: 00 first, 01 up, 10 down, 11 jump
- err  out  1  one-cycle pulse when a stable but undecodable pattern is accepted
- stable  out  1  high while the sampled pattern has met STABLE_CYCLES

Behaviour:
- Reset (async, reset=0): all registers clear. value=0, value_valid=0, update=0, dir=00, err=0, stable=0, FSM=S_EMPTY.
- Segment map (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - HEX1=1111111 (blank) decodes as tens=0.
  - Any other HEX1 pattern, or any unlisted or blank HEX0 pattern, is invalid.
- Sampling: both inputs are registered each cycle into samp[13:0].
  - cnt (4 bits) clears when the new sample differs from samp; otherwise it increments, saturating at STABLE_CYCLES.
  - stable = (cnt == STABLE_CYCLES).
- Acceptance fires in the cycle cnt first reaches STABLE_CYCLES. update/err are registered.
  - Latency: inputs changing before edge E and then held produce the pulse visible after edge E+STABLE_CYCLES+1.
- FSM states:
  - S_EMPTY: nothing accepted yet.
    - On valid acceptance: value<=decoded, value_valid<=1, dir<=00, update pulse, go S_HOLD.
    - On invalid acceptance: err pulse, stay.
  - S_HOLD: on acceptance, if decoded equals value, no pulse. Otherwise value<=decoded, update pulse, and dir is:
    - 01 if decoded==value+1, or value==WRAP_MAX and decoded==0
    - 10 if decoded==value-1, or value==0 and decoded==WRAP_MAX
    - 11 otherwise
  - S_HOLD on invalid acceptance: err pulse; value, value_valid and dir unchanged; stay.
  - S_HOLD return to S_EMPTY: only via reset.
- Glitches: a pattern held fewer than STABLE_CYCLES cycles is never accepted and produces no pulse. cnt restarts from 0 on every change.
- update and err are never asserted together. A pattern is accepted at most once until the sample changes again.
- Arithmetic: value = tens*10 + units, 7-bit unsigned. ±1 comparisons are done in 8 bits so 0-1 does not alias.
- Reset mid-settle: discards cnt and samp; no pulse is produced for that pattern.

Decomposition:
- Package seg7_pkg:
  - SEG_0..SEG_9 and SEG_BLANK localparams (7-bit)
  - dir_t enum {DIR_FIRST, DIR_UP, DIR_DOWN, DIR_JUMP}
  - state_t enum {S_EMPTY, S_HOLD}
- Sub-module seg7_decode: combinational, pattern -> {valid, digit[3:0]}, with a blank_ok input. Instantiated twice: HEX1 with blank_ok=1, HEX0 with blank_ok=0.

Test Plan:
- Reset, then HEX1=blank, HEX0=SEG_3, held 10 cycles -> one update at reset release+6 edges; value=3, dir=00, value_valid=1.
- From 3, drive SEG_4 held -> update, value=4, dir=01. Then SEG_3 -> value=3, dir=10.
- HEX1=SEG_9, HEX0=SEG_9 accepted, then HEX1=blank, HEX0=SEG_0 -> value=0, dir=01 (wrap). Reverse 0->99 -> dir=10.
- From 4, pulse HEX0=SEG_7 for 3 cycles, then back to SEG_4 -> no update, value stays 4.
  - Then hold SEG_7 -> update, dir=11.
- HEX0=1111111 held -> err one pulse, value unchanged. HEX0=0000001 held -> one err pulse. update stays 0 throughout.
- Assert reset=0 two cycles into settling of a new pattern -> all outputs 0 immediately; after release, re-acceptance reports dir=00.
